// File: rtl/run_length_detector.sv
// run_length_detector: Moore detector for RUN_LEN consecutive valid samples equal to match_val,
// with hold/re-arm modes and a saturating, clearable detection event counter.
module run_length_detector #(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8,
    parameter int RL_W    = $clog2(RUN_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             match_val,
    input  logic             rearm,
    input  logic             clear,
    output logic             detect,
    output logic [RL_W-1:0]  run_len,
    output logic [CNT_W-1:0] event_count,
    output logic             event_sat
);
    localparam logic [RL_W-1:0] FULL = RL_W'(RUN_LEN);
    localparam logic [RL_W-1:0] LAST = RL_W'(RUN_LEN - 1);

    logic [RL_W-1:0] cnt;
    logic            hit;
    logic            event_hit;

    assign hit       = in_bit == match_val;
    assign event_hit = in_valid && hit && cnt == LAST;
    assign detect    = cnt == FULL;
    assign run_len   = cnt;

    // clear outranks a same-cycle event and never touches the run count
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            event_count <= '0;
            event_sat   <= 1'b0;
        end else begin
            if (in_valid)
                cnt <= !hit ? '0 : cnt != FULL ? cnt + 1'b1 : rearm ? RL_W'(1) : cnt;
            if (clear) begin
                event_count <= '0;
                event_sat   <= 1'b0;
            end else if (event_hit) begin
                if (&event_count)
                    event_sat <= 1'b1;
                else
                    event_count <= event_count + 1'b1;
            end
        end
    end
endmodule
